// File: rtl/asic_ioctrl.sv
// -----------------------------------------------------------------------------
// asic_ioctrl -- core-side master of the padring control ring.
//
// Shifts a DW-bit pad configuration word (bit0 first) serially down the ring
// to the IO cells, one bit every DIV clk cycles, then issues a one-cycle
// update pulse and returns a response. When sense is enabled, the bits that
// come back on ring_in[3] are captured into a sense word and returned on
// rsp_data.
//
// Configuration macro:
//   ASIC_IOCTRL_SENSE_EN  defined   -> sense register built, rsp_data = sense word
//                         undefined -> no sense register, rsp_data = 0,
//                                      ring_in unused; timing is identical
//
// Ports:
//   clk        in   1         single clock, rising edge
//   nreset     in   1         synchronous active-low reset
//   req_valid  in   1         config word valid
//   req_ready  out  1         accepting a new config word (registered)
//   req_data   in   DW        config word, bit0 shifted first
//   rsp_valid  out  1         shift+update complete (registered)
//   rsp_ready  in   1         response consumed
//   rsp_data   out  DW        captured sense word (registered)
//   cfg_static in   NCTRL-4   static controls for ring lanes NCTRL-1:4
//   ring_out   out  NCTRL     [0]=sdo [1]=shift [2]=update [3]=0 [NCTRL-1:4]=static
//   ring_in    in   NCTRL     [3]=sdi, other lanes ignored
// -----------------------------------------------------------------------------
module asic_ioctrl #(
    parameter int NCTRL = 8,
    parameter int NPADS = 2,
    parameter int CFGW  = 4,
    parameter int DIV   = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NPADS*CFGW-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NPADS*CFGW-1:0] rsp_data,
    input  logic [NCTRL-5:0]      cfg_static,
    output logic [NCTRL-1:0]      ring_out,
    input  logic [NCTRL-1:0]      ring_in
);

    localparam int DW   = NPADS * CFGW;
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW   = $clog2(DW + 1);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DW-1:0]     shift_r;
    logic [DW-1:0]     shift_s;
    logic [DIVW-1:0]   div_r;
    logic [DIVW-1:0]   div_s;
    logic [BW-1:0]     bit_r;
    logic [BW-1:0]     bit_s;

    logic              sdo_s;
    logic              pulse_s;
    logic              update_s;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [NCTRL-1:0]  ring_r;

    // Last cycle of a bit period: data moves and the ring sees its shift strobe.
    logic              bit_end_s;
    assign bit_end_s = (state_r == ST_SHIFT) && (div_r == DIV_LAST);

    // Next-state, shift register and counter logic of the transfer FSM.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        div_s   = div_r;
        bit_s   = bit_r;
        case (state_r)
            ST_IDLE: begin
                // req_ready_r is used rather than the state so that the cycle
                // right after reset (IDLE but not yet ready) cannot accept.
                if (req_valid && req_ready_r) begin
                    state_s = ST_SHIFT;
                    shift_s = req_data;
                    div_s   = {DIVW{1'b0}};
                    bit_s   = {BW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s   = {DIVW{1'b0}};
                    shift_s = shift_r >> 1;
                    bit_s   = bit_r + BW'(1);
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_UPDATE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    div_s = div_r + DIVW'(1);
                end
            end
            ST_UPDATE: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Ring lane values for the next cycle, decoded from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        sdo_s    = 1'b0;
        pulse_s  = 1'b0;
        update_s = 1'b0;
        if (state_s == ST_SHIFT) begin
            sdo_s   = shift_s[0];
            pulse_s = (div_s == DIV_LAST);
        end else begin
            sdo_s   = 1'b0;
            pulse_s = 1'b0;
        end
        if (state_s == ST_UPDATE) begin
            update_s = 1'b1;
        end else begin
            update_s = 1'b0;
        end
    end

    // State, datapath and registered handshake/ring outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            shift_r     <= {DW{1'b0}};
            div_r       <= {DIVW{1'b0}};
            bit_r       <= {BW{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            ring_r      <= {NCTRL{1'b0}};
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            div_r       <= div_s;
            bit_r       <= bit_s;
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
            ring_r      <= {cfg_static, 1'b0, update_s, pulse_s, sdo_s};
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign ring_out  = ring_r;

`ifdef ASIC_IOCTRL_SENSE_EN
    logic [DW-1:0] sense_r;
    logic [DW-1:0] sense_s;
    logic [DW-1:0] rsp_data_r;
    logic          unused_ring_s;

    // Sense capture: sdi enters at the top so bit0 lands in bit0 after DW shifts.
    always_comb begin
        sense_s = sense_r;
        if (bit_end_s) begin
            sense_s = {ring_in[3], sense_r[DW-1:1]};
        end else if ((state_r == ST_IDLE) && req_valid && req_ready_r) begin
            sense_s = {DW{1'b0}};
        end else begin
            sense_s = sense_r;
        end
    end

    // Sense register and the response word presented while in RESP.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sense_r    <= {DW{1'b0}};
            rsp_data_r <= {DW{1'b0}};
        end else begin
            sense_r <= sense_s;
            if (state_s == ST_RESP) begin
                rsp_data_r <= sense_s;
            end else begin
                rsp_data_r <= {DW{1'b0}};
            end
        end
    end

    assign rsp_data      = rsp_data_r;
    assign unused_ring_s = ^{ring_in[NCTRL-1:4], ring_in[2:0], bit_r};
`else
    logic unused_ring_s;

    assign rsp_data      = {DW{1'b0}};
    assign unused_ring_s = ^{ring_in, bit_end_s, bit_r};
`endif

endmodule

// File: tb/tb_asic_ioctrl.sv
// -----------------------------------------------------------------------------
// tb_asic_ioctrl -- self-checking bench for asic_ioctrl (NCTRL=8, DW=8, DIV=2).
// The reference model states the expected ring behaviour per cycle of a
// transfer: cycle k after the accept carries bit (k-1)/DIV on sdo, a shift
// strobe when k is a multiple of DIV, the update strobe at DW*DIV+1 and the
// response from DW*DIV+2 on. Sense bit i is the sdi value seen in the cycle
// that ends bit period i (or the sent word itself when sdi loops back sdo).
// -----------------------------------------------------------------------------
module tb_asic_ioctrl;

    localparam int NCTRL     = 8;
    localparam int NPADS     = 2;
    localparam int CFGW      = 4;
    localparam int DIV       = 2;
    localparam int DW        = NPADS * CFGW;
    localparam int SW        = NCTRL - 4;
    localparam int SHIFT_CYC = DW * DIV;

    logic             clk = 1'b0;
    logic             nreset;
    logic             req_valid;
    logic             req_ready;
    logic [DW-1:0]    req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [SW-1:0]    cfg_static;
    logic [NCTRL-1:0] ring_out;
    logic [NCTRL-1:0] ring_in;

    int            n_checks = 0;
    int            n_fails  = 0;
    int            cyc      = 0;
    bit            loop_mode;
    logic          last_sdo;
    logic [SW-1:0] static_exp;
    int            hs_cyc;
    int            acc_cyc;
    int            rv_cyc;

    asic_ioctrl #(.NCTRL(NCTRL), .NPADS(NPADS), .CFGW(CFGW), .DIV(DIV)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .cfg_static (cfg_static),
        .ring_out   (ring_out),
        .ring_in    (ring_in)
    );

    always #5 clk = ~clk;

    // One clock: remember the static word sampled at the edge, then drive the
    // ring return (1-cycle loopback of sdo, or random sdi) and noise lanes.
    task automatic step();
        static_exp = cfg_static;
        @(posedge clk);
        #1;
        cyc++;
        ring_in    = NCTRL'($urandom);
        ring_in[3] = loop_mode ? last_sdo : 1'($urandom);
        last_sdo   = ring_out[0];
    endtask

    task automatic run_xfer(input logic [DW-1:0] data, input bit loop,
                            input int rsp_delay, input bit rand_busy);
        logic [DW-1:0]    rec;
        logic [DW-1:0]    exp_rsp;
        logic [NCTRL-1:0] exp_ro;
        int               n;
        loop_mode = loop;
        req_valid = 1'b1;
        req_data  = data;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
            n_fails++;
        end
        hs_cyc = cyc;
        step();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_data  = ~data;
        rec       = '0;
        for (int k = 1; k <= SHIFT_CYC + 1; k++) begin
            if (k <= SHIFT_CYC) begin
                exp_ro = {static_exp, 1'b0, 1'b0, ((k % DIV) == 0), data[(k - 1) / DIV]};
            end else begin
                exp_ro = {static_exp, 4'b0100};
            end
            n_checks++;
            if (ring_out !== exp_ro || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                $display("FAIL xfer_cycle: word %h cycle %0d got ring_out=%h req_ready=%b rsp_valid=%b, required ring_out=%h req_ready=0 rsp_valid=0",
                         data, k, ring_out, req_ready, rsp_valid, exp_ro);
                n_fails++;
            end
            if (k <= SHIFT_CYC && (k % DIV) == 0) begin
                rec[k / DIV - 1] = ring_in[3];
            end
            if (rand_busy) begin
                rsp_ready  = 1'($urandom);
                req_valid  = 1'($urandom);
                req_data   = DW'($urandom);
                cfg_static = SW'($urandom);
            end
            step();
        end
`ifdef ASIC_IOCTRL_SENSE_EN
        exp_rsp = loop ? data : rec;
`else
        exp_rsp = '0;
`endif
        rv_cyc = cyc;
        for (int j = 0; j <= rsp_delay; j++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || req_ready !== 1'b0 ||
                ring_out !== {static_exp, 4'h0}) begin
                $display("FAIL resp_hold: word %h wait %0d got rsp_valid=%b rsp_data=%h req_ready=%b ring_out=%h, required 1/%h/0/%h",
                         data, j, rsp_valid, rsp_data, req_ready, ring_out, exp_rsp, {static_exp, 4'h0});
                n_fails++;
            end
            rsp_ready = (j == rsp_delay);
            if (rand_busy) begin
                req_valid  = 1'($urandom);
                req_data   = DW'($urandom);
                cfg_static = SW'($urandom);
            end
            step();
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL turnaround: got rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
            n_fails++;
        end
    endtask

    task automatic test_reset();
        nreset     = 1'b0;
        req_valid  = 1'b1;
        req_data   = 8'hA5;
        rsp_ready  = 1'b1;
        cfg_static = 4'h9;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL reset_req_ready: got %b, required 0", req_ready);
            n_fails++;
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            $display("FAIL reset_rsp: got rsp_valid=%b rsp_data=%h, required 0/00", rsp_valid, rsp_data);
            n_fails++;
        end
        n_checks++;
        if (ring_out !== 8'h00) begin
            $display("FAIL reset_ring: got %h, required 00", ring_out);
            n_fails++;
        end
        nreset    = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ring_out !== 8'h90) begin
            $display("FAIL reset_release: got req_ready=%b rsp_valid=%b ring_out=%h, required 1/0/90",
                     req_ready, rsp_valid, ring_out);
            n_fails++;
        end
    endtask

    task automatic test_static();
        cfg_static = 4'h6;
        step();
        cfg_static = 4'h9;
        #1;
        n_checks++;
        if (ring_out[7:4] !== 4'h6) begin
            $display("FAIL static_delay: got %h before edge, required 6", ring_out[7:4]);
            n_fails++;
        end
        step();
        n_checks++;
        if (ring_out !== 8'h90) begin
            $display("FAIL static_update: got ring_out=%h, required 90", ring_out);
            n_fails++;
        end
    endtask

    task automatic test_shift();
        run_xfer(8'hA5, 1'b1, 0, 1'b0);
        n_checks++;
        if (rv_cyc - hs_cyc != SHIFT_CYC + 2) begin
            $display("FAIL latency: got %0d cycles, required %0d", rv_cyc - hs_cyc, SHIFT_CYC + 2);
            n_fails++;
        end
    endtask

    task automatic test_backpressure();
        run_xfer(8'h96, 1'b1, 5, 1'b1);
        run_xfer(8'h69, 1'b1, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        int rv_first;
        cfg_static = 4'h5;
        run_xfer(8'h3C, 1'b1, 0, 1'b0);
        rv_first = rv_cyc;
        run_xfer(8'hC3, 1'b1, 0, 1'b0);
        // rsp_valid in cycle t, IDLE in t+1, second word's first SHIFT cycle in t+2
        n_checks++;
        if (acc_cyc - rv_first != 2) begin
            $display("FAIL back_to_back: second transfer started %0d cycles after rsp_valid, required 2",
                     acc_cyc - rv_first);
            n_fails++;
        end
    endtask

    task automatic test_reset_midshift();
        int pulses;
        int upd;
        int rv;
        int n;
        loop_mode  = 1'b1;
        cfg_static = 4'h3;
        req_valid  = 1'b1;
        req_data   = 8'hA5;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        req_valid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 3 * DIV; k++) begin
            if (ring_out[1] === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses != 3) begin
            $display("FAIL midshift_pulses: got %0d shift pulses, required 3", pulses);
            n_fails++;
        end
        nreset = 1'b0;
        step();
        n_checks++;
        if (ring_out !== 8'h00 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL midshift_reset: got ring_out=%h req_ready=%b rsp_valid=%b, required 00/0/0",
                     ring_out, req_ready, rsp_valid);
            n_fails++;
        end
        nreset = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || ring_out !== 8'h30) begin
            $display("FAIL midshift_idle: got req_ready=%b ring_out=%h, required 1/30", req_ready, ring_out);
            n_fails++;
        end
        upd = 0;
        rv  = 0;
        for (int i = 0; i < 20; i++) begin
            if (ring_out[2] === 1'b1) upd++;
            if (rsp_valid === 1'b1) rv++;
            step();
        end
        n_checks++;
        if (upd != 0 || rv != 0) begin
            $display("FAIL midshift_no_update: got %0d update pulses and %0d rsp_valid cycles, required 0/0", upd, rv);
            n_fails++;
        end
        run_xfer(8'hFF, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            run_xfer(DW'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b1);
        end
    endtask

    initial begin
        nreset     = 1'b0;
        req_valid  = 1'b0;
        req_data   = '0;
        rsp_ready  = 1'b0;
        cfg_static = '0;
        ring_in    = '0;
        loop_mode  = 1'b1;
        last_sdo   = 1'b0;
        static_exp = '0;
        test_reset();
        test_static();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_midshift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
